uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter clk_freq, default 10000000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter baud_rate, default 9600, meaning the serial bit rate in bit/s.
REQ-003 The block SHALL have port clock, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit, the asynchronous serial line, idle high.
REQ-006 The block SHALL have port rd, input, 1 bit, a consumer read strobe that clears valid and overrun.
REQ-007 The block SHALL have port rx_data, output, 8 bits, the last correctly received byte.
REQ-008 The block SHALL have port donerx, output, 1 bit, a one-cycle pulse for each byte received with a good stop bit.
REQ-009 The block SHALL have port valid, output, 1 bit, high while an unread byte is held in rx_data.
REQ-010 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse when the stop bit samples 0.
REQ-011 The block SHALL have port overrun, output, 1 bit, a sticky flag set when a byte completes while valid is already 1.

Function
REQ-012 The block SHALL run entirely on clock, with no derived clock, using CPB = clk_freq/baud_rate (integer division) clocks per bit.
REQ-013 The block SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-014 The block SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 In IDLE, rxs=0 SHALL move the block to START and clear the bit counter.
REQ-016 In START, the block SHALL sample rxs at counter = CPB/2-1.
- rxs=0: go to DATA with the counter cleared.
- rxs=1: false start; return to IDLE with no output activity.
REQ-017 In DATA, the block SHALL sample rxs every CPB clocks, i.e. at mid-bit, and shift it into the shift register LSB first.
REQ-018 After the 8th sample, the block SHALL go to STOP.
REQ-019 In STOP, the block SHALL sample rxs after CPB clocks.
- rxs=1: on the next edge, load rx_data, pulse donerx for 1 cycle, set valid, and return to IDLE.
- rxs=0: pulse frame_err for 1 cycle, leave rx_data and valid unchanged, and go to WAIT_HIGH.
REQ-020 In WAIT_HIGH, the block SHALL stay until rxs=1, then go to IDLE, so a break condition never retriggers reception.
REQ-021 The latency from the rx falling edge of the start bit to the donerx pulse SHALL be 2 (synchronizer) + CPB/2 + 9*CPB + 1 clocks, ±1.
REQ-022 rd=1 SHALL clear valid and overrun on the next edge.
REQ-023 If a good stop bit occurs while valid=1 and rd=0, the block SHALL overwrite rx_data with the new byte, pulse donerx, and set overrun.
REQ-024 If a good stop bit coincides with rd=1, the block SHALL keep valid=1, load the new byte, and leave overrun clear.
REQ-025 rd while valid=0 SHALL have no effect.
REQ-026 donerx and frame_err SHALL never both be high in the same cycle.
REQ-027 rx_data SHALL be stable whenever donerx=0.
REQ-028 All counters SHALL be wide enough for CPB-1, and the bit index SHALL be 3 bits.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL apply the following reset values:
- state = IDLE, all counters = 0, shift register = 0.
- rx_data = 8'h00, donerx = 0, valid = 0, frame_err = 0, overrun = 0.
- both synchronizer flops = 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no donerx or frame_err pulse.
REQ-031 After reset is released mid-frame, the block SHALL treat the next low rxs as a start bit.

Verification
Bench parameters: clk_freq=1600000, baud_rate=100000 (CPB=16).
REQ-032 The bench SHALL drive frame 0x55 with stop=1 and check: one donerx pulse, rx_data=8'h55, valid=1, frame_err=0.
REQ-033 The bench SHALL drive 0xA3, then 0x3C without rd, and check: rx_data=8'h3C, overrun=1, valid=1; then rd=1 for 1 cycle and check valid=0, overrun=0.
REQ-034 The bench SHALL drive a rx low glitch of 4 clocks and check: no donerx, state back in IDLE, and a following 0x0F received correctly.
REQ-035 The bench SHALL drive frame 0xFF with stop=0, then hold rx low for 40 clocks, and check:
- one frame_err pulse, no donerx, rx_data unchanged.
- no reception starts until rx returns high.
- a subsequent 0x81 is received correctly.
REQ-036 The bench SHALL assert rst=0 for 2 cycles during bit 4 of 0xC6 and check: all outputs at reset values, no pulses, and the next frame 0x5A received as 8'h5A.
REQ-037 The bench SHALL assert rd in the same cycle that 0x12 completes while valid=1 and check: valid=1, overrun=0, rx_data=8'h12.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling from a single system clock.
// Holds the last good byte with valid/overrun status for a polled consumer.
module uart_rx #(
    parameter int clk_freq  = 10000000,
    parameter int baud_rate = 9600
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       donerx,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CPB = clk_freq / baud_rate;
    localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic          rx_s1;
    logic          rxs;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_tick;
    logic          good_stop;
    logic          bad_stop;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clock) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rxs   <= rx_s1;
        end
    end

    // Stop-bit decision, shared by the FSM and the status logic
    always_comb begin
        stop_tick = (state == STOP) && (cnt == FULL_M1);
        good_stop = stop_tick && rxs;
        bad_stop  = stop_tick && !rxs;
    end

    // Frame FSM: half-bit start qualification, then full-bit sampling
    always_ff @(posedge clock) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start bit
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output register, pulses and consumer status flags
    always_ff @(posedge clock) begin
        if (!rst) begin
            rx_data   <= 8'h00;
            donerx    <= 1'b0;
            frame_err <= 1'b0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            donerx    <= good_stop;
            frame_err <= bad_stop;
            if (good_stop) begin
                rx_data <= shreg;
                valid   <= 1'b1;
                // A read landing on the same edge consumes the old byte
                overrun <= rd ? 1'b0 : (overrun | valid);
            end else if (rd) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CPB=16.
// Directed scenarios plus random frames checked against a byte-level model.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       rst   = 1'b0;
    logic       rx    = 1'b1;
    logic       rd    = 1'b0;
    logic [7:0] rx_data;
    logic       donerx;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0;
    int n_ferr = 0;
    int n_both = 0;
    int n_unstable = 0;
    int t_fall = 0;
    int t_done = 0;
    logic [7:0] prev_data = 8'h00;

    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ovr = 1'b0;

    uart_rx #(
        .clk_freq (1600000),
        .baud_rate(100000)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .rx       (rx),
        .rd       (rd),
        .rx_data  (rx_data),
        .donerx   (donerx),
        .valid    (valid),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse counting and invariant watch, away from the active edge
    always @(negedge clock) begin
        if (donerx) begin
            n_done++;
            t_done = cyc;
        end
        if (frame_err) n_ferr++;
        if (donerx && frame_err) n_both++;
        if (rst && !donerx && (rx_data !== prev_data)) n_unstable++;
        prev_data = rx_data;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    // Start bit falls just after a clock edge; rx ends at the stop level
    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(posedge clock);
        #1;
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (stop) begin
            if (exp_valid) exp_ovr = 1'b1;
            exp_valid = 1'b1;
            exp_data  = d;
        end
    endtask

    task automatic do_rd();
        @(posedge clock);
        #1 rd = 1'b1;
        @(posedge clock);
        #1 rd = 1'b0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic frame_check(input string tag, input int d0, input int f0,
                               input int dd, input int df);
        @(negedge clock);
        check({tag, ".done"}, n_done - d0, dd);
        check({tag, ".ferr"}, n_ferr - f0, df);
        check({tag, ".data"}, rx_data, exp_data);
        check({tag, ".valid"}, valid, exp_valid);
        check({tag, ".ovr"}, overrun, exp_ovr);
    endtask

    task automatic gap(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    int d0, f0, lat;
    logic [7:0] b, c6;
    logic good;

    initial begin
        // Power-on reset
        repeat (3) @(posedge clock);
        #1 rst = 1'b1;
        @(negedge clock);
        check("rst.data", rx_data, 8'h00);
        check("rst.done", donerx, 1'b0);
        check("rst.valid", valid, 1'b0);
        check("rst.ferr", frame_err, 1'b0);
        check("rst.ovr", overrun, 1'b0);
        gap(2 * CPB);

        // Basic frame and start-to-done latency
        d0 = n_done; f0 = n_ferr;
        send_byte(8'h55, 1'b1);
        model_frame(8'h55, 1'b1);
        frame_check("f55", d0, f0, 1, 0);
        lat = t_done - t_fall;
        check("latency", (lat >= 154 && lat <= 156), 1'b1);
        gap(CPB);

        // Two unread bytes: overwrite plus overrun, then read clears
        d0 = n_done; f0 = n_ferr;
        send_byte(8'hA3, 1'b1);
        model_frame(8'hA3, 1'b1);
        gap(4);
        send_byte(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        frame_check("ovr", d0, f0, 2, 0);
        do_rd();
        @(negedge clock);
        check("rd.valid", valid, 1'b0);
        check("rd.ovr", overrun, 1'b0);
        gap(CPB);

        // Short low glitch is rejected as a false start
        d0 = n_done; f0 = n_ferr;
        @(posedge clock);
        #1 rx = 1'b0;
        repeat (4) @(posedge clock);
        #1 rx = 1'b1;
        gap(2 * CPB);
        @(negedge clock);
        check("glitch.done", n_done - d0, 0);
        check("glitch.state", dut.state, 3'd0);
        send_byte(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1);
        frame_check("f0F", d0, f0, 1, 0);
        gap(CPB);

        // Framing error followed by a held-low break
        d0 = n_done; f0 = n_ferr;
        send_byte(8'hFF, 1'b0);
        repeat (40) @(posedge clock);
        @(negedge clock);
        check("brk.ferr", n_ferr - f0, 1);
        check("brk.state", dut.state, 3'd4);
        #1 rx = 1'b1;
        gap(12 * CPB);
        frame_check("brk", d0, f0, 0, 1);
        send_byte(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        frame_check("f81", d0, f0, 1, 1);
        gap(CPB);

        // Reset during bit 4 aborts the frame silently
        d0 = n_done; f0 = n_ferr;
        c6 = 8'hC6;
        @(posedge clock);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(c6[i]);
        rx = c6[4];
        repeat (CPB / 2) @(posedge clock);
        #1 rst = 1'b0;
        repeat (2) @(posedge clock);
        #1 rst = 1'b1;
        rx = 1'b1;
        exp_data = 8'h00; exp_valid = 1'b0; exp_ovr = 1'b0;
        @(negedge clock);
        check("mrst.data", rx_data, 8'h00);
        check("mrst.valid", valid, 1'b0);
        check("mrst.ovr", overrun, 1'b0);
        gap(12 * CPB);
        frame_check("mrst", d0, f0, 0, 0);
        send_byte(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1);
        frame_check("f5A", d0, f0, 1, 0);
        gap(CPB);

        // Read coinciding with completion keeps valid, no overrun
        do_rd();
        d0 = n_done; f0 = n_ferr;
        send_byte(8'h34, 1'b1);
        model_frame(8'h34, 1'b1);
        gap(4);
        fork
            send_byte(8'h12, 1'b1);
            begin
                @(posedge clock);
                repeat (154) @(posedge clock);
                #1 rd = 1'b1;
                @(posedge clock);
                #1 rd = 1'b0;
            end
        join
        exp_data = 8'h12; exp_valid = 1'b1; exp_ovr = 1'b0;
        frame_check("rdco", d0, f0, 2, 0);
        gap(CPB);

        // Random frames with random reads and occasional bad stop bits
        for (int k = 0; k < 12; k++) begin
            d0 = n_done; f0 = n_ferr;
            b = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) do_rd();
            send_byte(b, good);
            model_frame(b, good);
            frame_check("rnd", d0, f0, good ? 1 : 0, good ? 0 : 1);
            gap($urandom_range(3, 20));
        end

        check("inv.both", n_both, 0);
        check("inv.stable", n_unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
